// File: rtl/alu_handshake_if.sv
// Request/response bus for alu_handshake: valid/ready request side, valid/ready result side.
// Optional zero/ovf flag signals exist only when ALU_HANDSHAKE_FLAGS_EN is defined.
interface alu_handshake_if #(
    parameter int WIDTH = 32
) ();
    // Handshake rule: a transfer happens on a rising clk edge where valid and ready are both 1;
    // the producer holds its payload while valid=1 and ready=0.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic [1:0]       state;
`ifdef ALU_HANDSHAKE_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output in_valid, output a, output b, output f, output out_ready,
        input  in_ready, input out_valid, input r, input busy, input state
`ifdef ALU_HANDSHAKE_FLAGS_EN
        , input zero, input ovf
`endif
    );

    modport slave (
        input  in_valid, input a, input b, input f, input out_ready,
        output in_ready, output out_valid, output r, output busy, output state
`ifdef ALU_HANDSHAKE_FLAGS_EN
        , output zero, output ovf
`endif
    );
endinterface

// File: rtl/alu_handshake.sv
// Sequential ALU behind a valid/ready interface, with an iterative shift-add multiply.
// Define ALU_HANDSHAKE_FLAGS_EN to add registered zero/ovf result flags.
module alu_handshake #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           reset,
    alu_handshake_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL = 3'b011;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_step;
    logic [WIDTH-1:0] r_q, alu_res, sum, diff;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_last;

    assign sum      = bus.a + bus.b;
    assign diff     = bus.a - bus.b;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        alu_res = '0;
        case (bus.f)
            3'b000:  alu_res = bus.a & bus.b;
            3'b001:  alu_res = bus.a | bus.b;
            3'b010:  alu_res = sum;
            3'b100:  alu_res = bus.a & ~bus.b;
            3'b101:  alu_res = bus.a | ~bus.b;
            3'b110:  alu_res = diff;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;  // multiply result comes from the accumulator
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = (bus.f == F_MUL) ? BUSY : DONE;
            BUSY:    if (mul_last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.f == F_MUL) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            r_q <= alu_res;
                        end
                    end
                end
                BUSY: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) r_q <= acc_step;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_HANDSHAKE_FLAGS_EN
    logic zero_q, ovf_q, alu_ovf;

    // Signed overflow: operands' sign bits vs. result sign bit
    always_comb begin
        alu_ovf = 1'b0;
        if (bus.f == 3'b010)
            alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        else if (bus.f == 3'b110)
            alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid && bus.f != F_MUL) begin
            zero_q <= (alu_res == '0);
            ovf_q  <= alu_ovf;
        end else if (state_q == BUSY && mul_last) begin
            zero_q <= (acc_step == '0);
            ovf_q  <= 1'b0;
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.r         = r_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_alu_handshake.sv
// Directed self-checking bench for alu_handshake (32-bit build).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_handshake;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  alu_handshake_if #(.WIDTH(32)) bus ();

  alu_handshake #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       output logic [31:0] res, output int lat, output int busy_n,
                       output logic zf, output logic of, output logic dropped);
    bus.a = a;
    bus.b = b;
    bus.f = f;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.r;
    zf = 1'b0;
    of = 1'b0;
`ifdef ALU_HANDSHAKE_FLAGS_EN
    zf = bus.zero;
    of = bus.ovf;
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    dropped = !bus.out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.r !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", bus.r); end
    n_checks++;
    if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    bus.a = 32'd5;
    bus.b = 32'd7;
    bus.f = 3'b010;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.r !== 32'd12) begin
      n_fail++; $display("FAIL add_result: got v=%b r=%h want v=1 r=0000000c", bus.out_valid, bus.r);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_done: got %b want 0", bus.in_ready); end
`ifdef ALU_HANDSHAKE_FLAGS_EN
    n_checks++;
    if (bus.zero !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++; $display("FAIL add_flags: got z=%b o=%b want 0/0", bus.zero, bus.ovf);
    end
`endif
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL add_hold: got v=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_release: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sub_slt();
    logic [31:0] res;
    int lat, bn;
    logic zf, of, dr;
    do_op(32'd3, 32'd5, 3'b110, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'hFFFF_FFFE || lat !== 1) begin
      n_fail++; $display("FAIL sub: got r=%h lat=%0d want fffffffe lat=1", res, lat);
    end
`ifdef ALU_HANDSHAKE_FLAGS_EN
    n_checks++;
    if (of !== 1'b0 || zf !== 1'b0) begin n_fail++; $display("FAIL sub_flags: got z=%b o=%b want 0/0", zf, of); end
`endif
    do_op(32'hFFFF_FFFF, 32'd1, 3'b111, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'd1) begin n_fail++; $display("FAIL slt_neg_lt_pos: got %h want 00000001", res); end
    do_op(32'd1, 32'hFFFF_FFFF, 3'b111, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'd0) begin n_fail++; $display("FAIL slt_pos_lt_neg: got %h want 00000000", res); end
    do_op(32'h7FFF_FFFF, 32'd1, 3'b010, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'h8000_0000 || !dr) begin
      n_fail++; $display("FAIL add_wrap: got r=%h dropped=%b want 80000000 dropped=1", res, dr);
    end
`ifdef ALU_HANDSHAKE_FLAGS_EN
    n_checks++;
    if (of !== 1'b1 || zf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got z=%b o=%b want 0/1", zf, of); end
`endif
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat, bn;
    logic zf, of, dr;
    do_op(32'd1234, 32'd5678, 3'b011, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'd7006652) begin n_fail++; $display("FAIL mul_result: got %0d want 7006652", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_checks++;
    if (bn !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", bn); end
    do_op(32'h0001_0000, 32'h0001_0000, 3'b011, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'h0 || lat !== 33) begin
      n_fail++; $display("FAIL mul_wrap: got r=%h lat=%0d want 0 lat=33", res, lat);
    end
`ifdef ALU_HANDSHAKE_FLAGS_EN
    n_checks++;
    if (zf !== 1'b1 || of !== 1'b0) begin n_fail++; $display("FAIL mul_flags: got z=%b o=%b want 1/0", zf, of); end
`endif
  endtask

  task automatic test_backpressure();
    bus.a = 32'hF0F0_F0F0;
    bus.b = 32'hFF00_FF00;
    bus.f = 3'b000;
    bus.in_valid = 1'b1;
    tick();
    bus.a = 32'd1;
    bus.b = 32'd2;
    bus.f = 3'b001;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.r !== 32'hF000_F000 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got v=%b r=%h rdy=%b want 1 f000f000 0",
                 i, bus.out_valid, bus.r, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.r !== 32'hF000_F000) begin
      n_fail++; $display("FAIL backpressure_ignored_req: got v=%b r=%h want 0 f000f000", bus.out_valid, bus.r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bn;
    logic zf, of, dr;
    bus.a = 32'd1234;
    bus.b = 32'd5678;
    bus.f = 3'b011;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.state !== 2'd0 || bus.out_valid !== 1'b0 || bus.r !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got st=%0d v=%b r=%h busy=%b want 0 0 0 0", bus.state, bus.out_valid, bus.r, bus.busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mid_reset_no_result: got out_valid=%b at cycle %0d want 0", bus.out_valid, i);
        break;
      end
      tick();
    end
    do_op(32'd1, 32'd2, 3'b001, res, lat, bn, zf, of, dr);
    n_checks++;
    if (res !== 32'd3 || lat !== 1) begin
      n_fail++; $display("FAIL or_after_reset: got r=%h lat=%0d want 00000003 lat=1", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tab[8];
    logic [31:0] exp;
    int cycles;
    exp_tab[0] = 32'h0000_0030;
    exp_tab[1] = 32'h0000_00FC;
    exp_tab[2] = 32'h0000_012C;
    exp_tab[3] = 32'h0000_3840;
    exp_tab[4] = 32'h0000_00C0;
    exp_tab[5] = 32'hFFFF_FFF3;
    exp_tab[6] = 32'h0000_00B4;
    exp_tab[7] = 32'h0000_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_tab[i]);
      bus.a = 32'h0000_00F0;
      bus.b = 32'h0000_003C;
      bus.f = 3'(i);
      bus.in_valid = 1'b1;
      tick();
      cycles = 1;
      while (!bus.out_valid && cycles < 64) begin
        tick();
        cycles++;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.r !== exp || cycles !== ((i == 3) ? 33 : 1)) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got v=%b r=%h lat=%0d want r=%h lat=%0d",
                 i, bus.out_valid, bus.r, cycles, exp, (i == 3) ? 33 : 1);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_release%0d: got v=%b rdy=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_queue: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.f = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
